// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared definitions for the iterative fixed-point square-root unit.
//   - state_t    : FSM state encoding (IDLE, CALC, FIN, DONE)
//   - root_width : root width for a given radicand width and fractional bits
package sqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Integer part of the root is WIDTH/2 bits; FRAC_OUT fractional bits follow.
    function automatic int root_width(input int width, input int frac_out);
        return (width >> 1) + frac_out;
    endfunction

endpackage

// File: rtl/sqrt_fixed_iter_step.sv
// sqrt_fixed_iter_step: one iteration of the restoring digit-by-digit square
// root recurrence (purely combinational).
//   rem_in   : partial remainder (ROOT_W+2 bits)
//   root_in  : partial root (ROOT_W bits)
//   pair_in  : next two radicand bits, MSB pair first
//   rem_out  : updated remainder
//   root_out : updated root (one new bit appended at the LSB)
module sqrt_fixed_iter_step #(
    parameter int ROOT_W = 14
) (
    input  logic [ROOT_W+1:0] rem_in,
    input  logic [ROOT_W-1:0] root_in,
    input  logic [1:0]        pair_in,
    output logic [ROOT_W+1:0] rem_out,
    output logic [ROOT_W-1:0] root_out
);

    logic [ROOT_W+1:0] trial_rem;
    logic [ROOT_W+1:0] trial_sub;
    logic              take;
    logic [ROOT_W-1:0] take_vec;

    // The remainder never exceeds 2*root, so with at most ROOT_W-1 root bits
    // settled, (rem<<2)|pair still fits in ROOT_W+2 bits; the bits shifted out
    // are always zero.
    assign trial_rem = (rem_in << 2) | {{ROOT_W{1'b0}}, pair_in};
    assign trial_sub = {root_in, 2'b01};
    assign take      = (trial_rem >= trial_sub);
    assign take_vec  = ROOT_W'(take);

    assign rem_out  = take ? (trial_rem - trial_sub) : trial_rem;
    assign root_out = (root_in << 1) | take_vec;

endmodule

// File: rtl/sqrt_fixed_iter.sv
// sqrt_fixed_iter: iterative fixed-point square root, one root bit per cycle.
//   root = floor(sqrt(in_data * 2^(2*FRAC_OUT))), optionally rounded to
//   nearest with saturation at all-ones. rem is always the remainder of the
//   truncated root; exact flags rem == 0.
// Ports:
//   clk, rst (async, active-low)
//   in_valid / in_ready / in_data / round_en : radicand handshake
//   out_valid / out_ready / root / rem / exact : result handshake
// Accept at edge N -> out_valid after edge N+ROOT_W+1; results are held
// until out_ready, then the unit returns to IDLE on the next edge.
module sqrt_fixed_iter
    import sqrt_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int FRAC_OUT = 6,
    localparam int ROOT_W  = root_width(WIDTH, FRAC_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              round_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROOT_W-1:0] root,
    output logic [ROOT_W:0]   rem,
    output logic              exact
);

    localparam int RAD_W = 2 * ROOT_W;
    localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    state_t            state_reg;
    logic [RAD_W-1:0]  rad_reg;
    logic              rnd_reg;
    logic [ROOT_W-1:0] root_acc_reg;
    logic [ROOT_W+1:0] rem_acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ROOT_W-1:0] root_reg;
    logic [ROOT_W:0]   rem_reg;
    logic              exact_reg;
    logic              out_valid_reg;
    logic              in_ready_reg;

    logic [ROOT_W+1:0] step_rem_next;
    logic [ROOT_W-1:0] step_root_next;
    logic              round_up;
    logic              root_sat;
    logic [ROOT_W-1:0] root_fin_next;

    sqrt_fixed_iter_step #(
        .ROOT_W (ROOT_W)
    ) u_step (
        .rem_in   (rem_acc_reg),
        .root_in  (root_acc_reg),
        .pair_in  (rad_reg[RAD_W-1 -: 2]),
        .rem_out  (step_rem_next),
        .root_out (step_root_next)
    );

    // Round up when R >= (root + 0.5)^2, i.e. rem >= root + 0.25, which for
    // integers is rem > root. An all-ones root cannot be incremented.
    assign round_up      = rnd_reg && (rem_acc_reg > (ROOT_W+2)'(root_acc_reg));
    assign root_sat      = &root_acc_reg;
    assign root_fin_next = (round_up && !root_sat) ? (root_acc_reg + 1'b1) : root_acc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            rad_reg       <= '0;
            rnd_reg       <= 1'b0;
            root_acc_reg  <= '0;
            rem_acc_reg   <= '0;
            cnt_reg       <= '0;
            root_reg      <= '0;
            rem_reg       <= '0;
            exact_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        rad_reg      <= RAD_W'(in_data) << (2 * FRAC_OUT);
                        rnd_reg      <= round_en;
                        root_acc_reg <= '0;
                        rem_acc_reg  <= '0;
                        cnt_reg      <= CNT_W'(ROOT_W - 1);
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem_acc_reg  <= step_rem_next;
                    root_acc_reg <= step_root_next;
                    rad_reg      <= rad_reg << 2;
                    if (cnt_reg == '0) begin
                        state_reg <= ST_FIN;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_FIN: begin
                    root_reg      <= root_fin_next;
                    rem_reg       <= rem_acc_reg[ROOT_W:0];
                    exact_reg     <= (rem_acc_reg == '0);
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign root      = root_reg;
    assign rem       = rem_reg;
    assign exact     = exact_reg;

endmodule

// File: tb/tb_sqrt_fixed_iter.sv
// tb_sqrt_fixed_iter: directed + random scoreboard bench for sqrt_fixed_iter
// (default parameters WIDTH=16, FRAC_OUT=6, ROOT_W=14).
module tb_sqrt_fixed_iter;

    localparam int WIDTH    = 16;
    localparam int FRAC_OUT = 6;
    localparam int ROOT_W   = 14;
    localparam int LATENCY  = ROOT_W + 1;
    localparam int TIMEOUT  = 100;

    typedef struct packed {
        logic [ROOT_W-1:0] root;
        logic [ROOT_W:0]   rem;
        logic              exact;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              round_en;
    logic              out_valid;
    logic              out_ready;
    logic [ROOT_W-1:0] root;
    logic [ROOT_W:0]   rem;
    logic              exact;

    exp_t    exp_q[$];
    int      errors = 0;
    int      checks = 0;
    longint  cyc = 0;
    longint  acc_cyc = 0;

    sqrt_fixed_iter #(
        .WIDTH    (WIDTH),
        .FRAC_OUT (FRAC_OUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .round_en  (round_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root      (root),
        .rem       (rem),
        .exact     (exact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: binary-search integer sqrt, rounding decided by (2r+1)^2 <= 4R.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic rnd);
        exp_t   e;
        longint r_val;
        longint lo;
        longint hi;
        longint mid;
        longint rm;
        longint rt;
        r_val = longint'(d) * 4096;
        lo = 0;
        hi = 16383;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= r_val) lo = mid;
            else hi = mid - 1;
        end
        rm = r_val - lo * lo;
        rt = lo;
        if (rnd && ((2 * lo + 1) * (2 * lo + 1) <= 4 * r_val))
            rt = (lo == 16383) ? 16383 : lo + 1;
        e.root  = ROOT_W'(rt);
        e.rem   = (ROOT_W+1)'(rm);
        e.exact = (rm == 0);
        return e;
    endfunction

    task automatic send_exp(input logic [WIDTH-1:0] d, input logic rnd, input exp_t e);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        round_en = rnd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic send_model(input logic [WIDTH-1:0] d, input logic rnd);
        send_exp(d, rnd, model(d, rnd));
    endtask

    task automatic receive(input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", 64'(out_valid), 64'd1);
        chk("latency", 64'(cyc - acc_cyc), 64'(LATENCY));
        e = exp_q.pop_front();
        chk("root", 64'(root), 64'(e.root));
        chk("rem", 64'(rem), 64'(e.rem));
        chk("exact", 64'(exact), 64'(e.exact));
        $display("op: root=%0d rem=%0d exact=%0d (exp %0d/%0d/%0d) latency=%0d",
                 root, rem, exact, e.root, e.rem, e.exact, cyc - acc_cyc);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            round_en = 1'b0;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_root", 64'(root), 64'(e.root));
            chk("hold_rem", 64'(rem), 64'(e.rem));
            chk("hold_exact", 64'(exact), 64'(e.exact));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_out_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    function automatic exp_t mk(input int r, input int m, input logic x);
        exp_t e;
        e.root  = ROOT_W'(r);
        e.rem   = (ROOT_W+1)'(m);
        e.exact = x;
        return e;
    endfunction

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        round_en  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_root", 64'(root), 64'd0);
        chk("rst_rem", 64'(rem), 64'd0);
        chk("rst_exact", 64'(exact), 64'd0);
        rst = 1'b1;

        // Directed vectors with hand-computed results.
        send_exp(16'd0, 1'b0, mk(0, 0, 1'b1));          receive(0);
        send_exp(16'd4, 1'b0, mk(128, 0, 1'b1));        receive(0);
        send_exp(16'd2, 1'b0, mk(90, 92, 1'b0));        receive(0);
        send_exp(16'd2, 1'b1, mk(91, 92, 1'b0));        receive(0);
        send_exp(16'd3, 1'b1, mk(111, 188, 1'b0));      receive(0);
        send_exp(16'd3, 1'b0, mk(110, 188, 1'b0));      receive(0);
        send_exp(16'd65535, 1'b1, mk(16383, 28671, 1'b0)); receive(0);

        // Backpressure in DONE with in_valid asserted, then a follow-up op.
        send_model(16'd50, 1'b1);  receive(10);
        send_model(16'd7, 1'b0);   receive(0);

        // Random radicands against the reference model.
        for (int i = 0; i < 6; i++) begin
            send_model(WIDTH'($urandom), 1'($urandom_range(0, 1)));
            receive(0);
        end

        // Asynchronous reset in the middle of CALC discards the operation.
        send_model(16'd1000, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("abort_no_output", 64'(out_valid), 64'd0);
        end
        send_exp(16'd9, 1'b0, mk(192, 0, 1'b1));        receive(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
